// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the fetch PC, issues pipelined memory requests and
// buffers in-order responses in a DEPTH-entry queue that feeds decode.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            btb_hit,
  input  logic            btb_taken,
  input  logic [XLEN-1:0] btb_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_target
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [PW-1:0]   discard_q, discard_d;

  logic [XLEN-1:0] slot_pc_q     [DEPTH];
  logic [XLEN-1:0] slot_pc_d     [DEPTH];
  logic [XLEN-1:0] slot_target_q [DEPTH];
  logic [XLEN-1:0] slot_target_d [DEPTH];
  logic            slot_taken_q  [DEPTH];
  logic            slot_taken_d  [DEPTH];
  logic [31:0]     slot_instr_q  [DEPTH];
  logic [31:0]     slot_instr_d  [DEPTH];

  logic [PW-1:0] alloc_cnt, pend_cnt;
  logic          req_fire, pop, pred_taken;

  assign alloc_cnt  = tail_q - head_q;
  assign pend_cnt   = tail_q - fill_q;
  assign pred_taken = btb_hit && btb_taken;

  // Gated by rst so the request drops the instant reset asserts.
  assign imem_req_valid = rst && !redirect_en && (alloc_cnt < DEPTH_P);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid       = (fill_q != head_q);
  assign out_instr       = slot_instr_q[head_q[AW-1:0]];
  assign out_pc          = slot_pc_q[head_q[AW-1:0]];
  assign out_pred_taken  = slot_taken_q[head_q[AW-1:0]];
  assign out_pred_target = slot_target_q[head_q[AW-1:0]];
  assign pop             = out_valid && out_ready;

  always_comb begin
    pc_d          = pc_q;
    head_d        = head_q;
    fill_d        = fill_q;
    tail_d        = tail_q;
    discard_d     = discard_q;
    slot_pc_d     = slot_pc_q;
    slot_target_d = slot_target_q;
    slot_taken_d  = slot_taken_q;
    slot_instr_d  = slot_instr_q;

    if (redirect_en) begin
      // Everything still in flight becomes stale; a response landing now is one of them.
      head_d    = '0;
      fill_d    = '0;
      tail_d    = '0;
      pc_d      = redirect_pc;
      discard_d = discard_q + pend_cnt - PW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        slot_pc_d[tail_q[AW-1:0]]     = pc_q;
        slot_taken_d[tail_q[AW-1:0]]  = pred_taken;
        slot_target_d[tail_q[AW-1:0]] = btb_target;
        tail_d = tail_q + PW'(1);
        pc_d   = pred_taken ? btb_target : pc_q + XLEN'(4);
      end
      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - PW'(1);
        end else begin
          slot_instr_d[fill_q[AW-1:0]] = imem_rsp_data;
          fill_d = fill_q + PW'(1);
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      head_q    <= '0;
      fill_q    <= '0;
      tail_q    <= '0;
      discard_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]     <= '0;
        slot_target_q[i] <= '0;
        slot_taken_q[i]  <= 1'b0;
        slot_instr_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      fill_q        <= fill_d;
      tail_q        <= tail_d;
      discard_q     <= discard_d;
      slot_pc_q     <= slot_pc_d;
      slot_target_q <= slot_target_d;
      slot_taken_q  <= slot_taken_d;
      slot_instr_q  <= slot_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus a randomized soak, checked against
// a queue-level reference model of the fetch stream and an in-order variable-latency memory.
module tb_fetch_queue_stage;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_en    = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        btb_hit        = 1'b0;
  logic        btb_taken      = 1'b0;
  logic [31:0] btb_target     = '0;
  logic        out_valid;
  logic        out_ready      = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  fetch_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .btb_hit(btb_hit), .btb_taken(btb_taken), .btb_target(btb_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // memory: outstanding responses in issue order
  int          mem_due[$];
  logic [31:0] mem_dat[$];
  int          last_due;

  // reference model: allocated entries in order, with the instructions returned so far
  logic [31:0] mpc;
  logic [31:0] q_pc[$];
  logic [31:0] q_tgt[$];
  logic        q_tk[$];
  logic [31:0] q_instr[$];
  int          ndiscard;

  // stimulus knobs
  int          lat_min = 1, lat_max = 1, ready_pct = 100, oready_pct = 100, redir_pct = 0;
  int          btb_mode = 0;
  logic        force_redir = 1'b0;
  logic [31:0] force_rpc = '0;

  // last step's observations
  logic        obs_req_valid, obs_acc, obs_out_valid, obs_tk;
  logic [31:0] obs_addr, obs_out_pc, obs_instr, obs_tgt;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpc = RESET_PC;
    q_pc.delete(); q_tgt.delete(); q_tk.delete(); q_instr.delete();
    ndiscard = 0;
    mem_due.delete(); mem_dat.delete();
    last_due = 0;
  endtask

  // Called just after a falling edge; leaves the bench just after a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    redirect_en = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0;
    btb_hit = 1'b0; btb_taken = 1'b0; btb_target = '0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_taken", out_pred_taken, 1'b0);
    chk("rst_out_target", out_pred_target, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    logic        exp_rv, exp_ov, acc, rsp, tk;
    int          due;
    rsp = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_dat[0] : $urandom;
    imem_req_ready = (mem_due.size() < DEPTH) && ($urandom_range(0, 99) < ready_pct);
    out_ready      = ($urandom_range(0, 99) < oready_pct);
    redirect_en    = force_redir || ($urandom_range(0, 99) < redir_pct);
    redirect_pc    = force_redir ? force_rpc : ($urandom_range(0, 1023) << 2);
    btb_taken      = $urandom_range(0, 1);
    btb_target     = $urandom & 32'hFFFF_FFFC;
    btb_hit        = 1'b0;
    if (btb_mode == 1 && mpc == 32'h8) begin
      btb_hit = 1'b1; btb_taken = 1'b1; btb_target = 32'h100;
    end else if (btb_mode == 2 && mpc[5:2] == 4'd5) begin
      btb_hit = 1'b1; btb_target = (mpc + 32'h80) & 32'h0000_0FFC;
    end
    #1;
    exp_rv = !redirect_en && (q_pc.size() < DEPTH);
    exp_ov = (q_instr.size() > 0);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, mpc);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_instr", out_instr, q_instr[0]);
      chk("out_pred_taken", out_pred_taken, q_tk[0]);
      chk("out_pred_target", out_pred_target, q_tgt[0]);
    end
    obs_req_valid = imem_req_valid; obs_addr = imem_req_addr;
    obs_acc = imem_req_valid && imem_req_ready;
    obs_out_valid = out_valid; obs_out_pc = out_pc; obs_instr = out_instr;
    obs_tk = out_pred_taken; obs_tgt = out_pred_target;

    acc = exp_rv && imem_req_ready;
    if (acc) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_due.push_back(due);
      mem_dat.push_back(memword(mpc));
    end
    if (rsp) begin
      void'(mem_due.pop_front());
      void'(mem_dat.pop_front());
    end

    if (redirect_en) begin
      ndiscard = ndiscard + (q_pc.size() - q_instr.size()) - (rsp ? 1 : 0);
      q_pc.delete(); q_tgt.delete(); q_tk.delete(); q_instr.delete();
      mpc = redirect_pc;
    end else begin
      if (rsp) begin
        if (ndiscard > 0) ndiscard--;
        else q_instr.push_back(imem_rsp_data);
      end
      if (exp_ov && out_ready) begin
        void'(q_pc.pop_front()); void'(q_tgt.pop_front());
        void'(q_tk.pop_front()); void'(q_instr.pop_front());
      end
      if (acc) begin
        tk = btb_hit && btb_taken;
        q_pc.push_back(mpc); q_tk.push_back(tk); q_tgt.push_back(btb_target);
        mpc = tk ? btb_target : mpc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int nreq;
    logic found;
    @(negedge clk);

    // A: streaming from reset, 1-cycle memory
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k >= 2 && k <= 5) begin
        chk("A_out_valid", obs_out_valid, 1'b1);
        chk("A_out_pc", obs_out_pc, 32'(4 * (k - 2)));
        chk("A_out_instr", obs_instr, memword(32'(4 * (k - 2))));
      end
    end

    // B: decode stalled, queue fills, one pop reopens fetch
    do_reset();
    oready_pct = 0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (obs_acc) nreq++;
    end
    chk("B_req_count", nreq, 4);
    chk("B_full_req_valid", obs_req_valid, 1'b0);
    oready_pct = 100;
    step();
    chk("B_pop_pc", obs_out_pc, 32'h0);
    step();
    chk("B_req16_valid", obs_req_valid, 1'b1);
    chk("B_req16_addr", obs_addr, 32'h10);

    // C: BTB taken at PC 8
    do_reset();
    btb_mode = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      case (k)
        0: chk("C_addr0", obs_addr, 32'h0);
        1: chk("C_addr1", obs_addr, 32'h4);
        2: chk("C_addr2", obs_addr, 32'h8);
        3: chk("C_addr3", obs_addr, 32'h100);
        4: begin
          chk("C_addr4", obs_addr, 32'h104);
          chk("C_pc8", obs_out_pc, 32'h8);
          chk("C_pc8_taken", obs_tk, 1'b1);
          chk("C_pc8_target", obs_tgt, 32'h100);
        end
        default: begin
          chk("C_pc100", obs_out_pc, 32'h100);
          chk("C_pc100_taken", obs_tk, 1'b0);
        end
      endcase
    end
    btb_mode = 0;

    // D: 3-cycle memory, redirect with two responses outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    step();
    step();
    force_redir = 1'b1; force_rpc = 32'h200;
    step();
    force_redir = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = obs_out_valid;
    end
    chk("D_found", found, 1'b1);
    chk("D_first_pc", obs_out_pc, 32'h200);
    chk("D_first_instr", obs_instr, memword(32'h200));
    lat_min = 1; lat_max = 1;

    // E: redirect coinciding with a response and a pop
    do_reset();
    step();
    step();
    force_redir = 1'b1; force_rpc = 32'h40;
    step();
    force_redir = 1'b0;
    chk("E_rsp_same_cycle", imem_rsp_valid, 1'b1);
    chk("E_pop_same_cycle", obs_out_valid, 1'b1);
    step();
    chk("E_empty", obs_out_valid, 1'b0);
    chk("E_req_valid", obs_req_valid, 1'b1);
    chk("E_req_addr", obs_addr, 32'h40);
    for (int k = 0; k < 4; k++) step();

    // soak: random latency, backpressure, redirects and BTB hits
    lat_min = 1; lat_max = 4; ready_pct = 70; oready_pct = 60; redir_pct = 4; btb_mode = 2;
    for (int k = 0; k < 1500; k++) step();

    // reset asserted with a full queue
    redir_pct = 0; oready_pct = 0; ready_pct = 100; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 15; k++) step();
    chk("F_full_out_valid", obs_out_valid, 1'b1);
    chk("F_full_req_valid", obs_req_valid, 1'b0);
    do_reset();
    btb_mode = 0; oready_pct = 100;
    step();
    chk("F_restart_valid", obs_req_valid, 1'b1);
    chk("F_restart_addr", obs_addr, RESET_PC);
    for (int k = 0; k < 6; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
